// File: rtl/si_tag_serializer.sv
// Tag serializer: captures a bundle of NUMBER_OF_WORDS tag lanes and emits the enabled
// ones one per cycle in ascending lane order, tracking a monotonic lower time bound.
module si_tag_serializer #(
    parameter int NUMBER_OF_WORDS = 4,
    parameter int CHANNEL_COUNT   = 20
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic [64*NUMBER_OF_WORDS-1:0] s_axis_tagtime,
    input  logic [6*NUMBER_OF_WORDS-1:0]  s_axis_channel,
    input  logic [NUMBER_OF_WORDS-1:0]    s_axis_tkeep,
    input  logic [63:0]                   s_lowest_time_bound,
    input  logic [2*CHANNEL_COUNT-1:0]    channel_enable,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [63:0]                   m_axis_tagtime,
    output logic signed [5:0]             m_axis_channel,
    output logic                          m_axis_tlast,
    output logic [63:0]                   lowest_time_bound,
    output logic [31:0]                   filtered_count
);

    localparam int N  = NUMBER_OF_WORDS;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, EMIT} state_t;

    state_t                 state_q;
    logic [N-1:0]           pending_q, pending_d;
    logic [63:0]            time_q [N];
    logic signed [5:0]      chan_q [N];
    logic [63:0]            held_q;
    logic [63:0]            low_q;
    logic [31:0]            filt_q;

    logic [N-1:0]           lane_en;
    logic [31:0]            drop_cnt;
    logic [32:0]            filt_sum;
    logic [IW-1:0]          sel_idx;
    logic                   in_hs, out_hs;

    // Per-lane enable lookup; channel 0 and magnitudes beyond CHANNEL_COUNT never match.
    always_comb begin
        lane_en  = '0;
        drop_cnt = '0;
        for (int i = 0; i < N; i++) begin
            for (int c = 1; c <= CHANNEL_COUNT; c++) begin
                if (s_axis_channel[6*i +: 6] == 6'(c))
                    lane_en[i] = channel_enable[c-1];
                if (s_axis_channel[6*i +: 6] == 6'(-c))
                    lane_en[i] = channel_enable[CHANNEL_COUNT+c-1];
            end
            drop_cnt = drop_cnt + {31'b0, s_axis_tkeep[i] & ~lane_en[i]};
        end
        filt_sum = {1'b0, filt_q} + {1'b0, drop_cnt};
    end

    always_comb begin
        sel_idx = '0;
        for (int i = N-1; i >= 0; i--) begin
            if (pending_q[i])
                sel_idx = IW'(i);
        end
    end

    assign m_axis_tvalid     = (state_q == EMIT);
    assign m_axis_tagtime    = time_q[sel_idx];
    assign m_axis_channel    = chan_q[sel_idx];
    assign m_axis_tlast      = (pending_q != '0) && ((pending_q & (pending_q - 1'b1)) == '0);
    assign s_axis_tready     = (pending_q == '0) || (m_axis_tready && m_axis_tlast);
    assign lowest_time_bound = low_q;
    assign filtered_count    = filt_q;

    assign in_hs  = s_axis_tvalid && s_axis_tready;
    assign out_hs = m_axis_tvalid && m_axis_tready;

    // A new bundle overwrites whatever is left of the old mask in the same cycle.
    always_comb begin
        pending_d = pending_q;
        if (out_hs)
            pending_d[sel_idx] = 1'b0;
        if (in_hs)
            pending_d = s_axis_tkeep & lane_en;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            held_q    <= '0;
            low_q     <= '0;
            filt_q    <= '0;
            for (int i = 0; i < N; i++) begin
                time_q[i] <= '0;
                chan_q[i] <= '0;
            end
        end else begin
            pending_q <= pending_d;
            state_q   <= (pending_d != '0) ? EMIT : IDLE;
            if (in_hs) begin
                for (int i = 0; i < N; i++) begin
                    time_q[i] <= s_axis_tagtime[64*i +: 64];
                    chan_q[i] <= $signed(s_axis_channel[6*i +: 6]);
                end
                held_q <= s_lowest_time_bound;
                filt_q <= filt_sum[32] ? 32'hFFFF_FFFF : filt_sum[31:0];
            end
            // Held bound only applies once nothing older is still waiting to be emitted.
            if (out_hs) begin
                if (m_axis_tagtime > low_q)
                    low_q <= m_axis_tagtime;
            end else if ((pending_q == '0) && (held_q > low_q)) begin
                low_q <= held_q;
            end
        end
    end

endmodule

// File: tb/tb_si_tag_serializer.sv
// Directed bench for si_tag_serializer: expected tags go to a scoreboard queue when a
// bundle is accepted and are compared as the DUT emits them.
module tb_si_tag_serializer;

    logic               clk = 1'b0;
    logic               rst;
    logic               s_axis_tvalid;
    logic               s_axis_tready;
    logic [255:0]       s_axis_tagtime;
    logic [23:0]        s_axis_channel;
    logic [3:0]         s_axis_tkeep;
    logic [63:0]        s_lowest_time_bound;
    logic [39:0]        channel_enable;
    logic               m_axis_tvalid;
    logic               m_axis_tready;
    logic [63:0]        m_axis_tagtime;
    logic signed [5:0]  m_axis_channel;
    logic               m_axis_tlast;
    logic [63:0]        lowest_time_bound;
    logic [31:0]        filtered_count;

    typedef struct {
        logic [63:0]       t;
        logic signed [5:0] c;
        logic              last;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          pop_count = 0;
    logic [31:0] exp_filt = 0;
    int          w;

    si_tag_serializer #(.NUMBER_OF_WORDS(4), .CHANNEL_COUNT(20)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .s_axis_tvalid       (s_axis_tvalid),
        .s_axis_tready       (s_axis_tready),
        .s_axis_tagtime      (s_axis_tagtime),
        .s_axis_channel      (s_axis_channel),
        .s_axis_tkeep        (s_axis_tkeep),
        .s_lowest_time_bound (s_lowest_time_bound),
        .channel_enable      (channel_enable),
        .m_axis_tvalid       (m_axis_tvalid),
        .m_axis_tready       (m_axis_tready),
        .m_axis_tagtime      (m_axis_tagtime),
        .m_axis_channel      (m_axis_channel),
        .m_axis_tlast        (m_axis_tlast),
        .lowest_time_bound   (lowest_time_bound),
        .filtered_count      (filtered_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic en_model(input logic signed [5:0] ch, input logic [39:0] mask);
        int          c;
        logic [39:0] sh;
        c = ch;
        if (c >= 1 && c <= 20) begin
            sh = mask >> (c - 1);
            return sh[0];
        end
        if (c <= -1 && c >= -20) begin
            sh = mask >> (20 - c - 1);
            return sh[0];
        end
        return 1'b0;
    endfunction

    // Scoreboard consumer: every output handshake must match the queue head.
    always @(negedge clk) begin
        if (!rst && m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_tag", m_axis_tagtime, 64'hDEAD);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("tag_time", m_axis_tagtime, e.t);
                check("tag_chan", 64'(m_axis_channel), 64'(e.c));
                check("tag_last", 64'(m_axis_tlast), 64'(e.last));
                pop_count++;
            end
        end
    end

    task automatic drive(input logic [63:0] t0, t1, t2, t3,
                         input logic signed [5:0] c0, c1, c2, c3,
                         input logic [3:0] keep, input logic [63:0] bound);
        s_axis_tagtime      = {t3, t2, t1, t0};
        s_axis_channel      = {c3, c2, c1, c0};
        s_axis_tkeep        = keep;
        s_lowest_time_bound = bound;
        s_axis_tvalid       = 1'b1;
    endtask

    // Waits for acceptance, loads the scoreboard, returns #1 after the accepting edge.
    task automatic accept(output int waited);
        int          last_lane;
        logic [32:0] sum;
        logic [31:0] dropped;
        logic [3:0]  en;
        waited = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            waited++;
            if (s_axis_tready) break;
        end
        check("accept_timeout", 64'(s_axis_tready), 64'd1);
        dropped   = 0;
        last_lane = -1;
        for (int i = 0; i < 4; i++) begin
            en[i] = en_model($signed(s_axis_channel[6*i +: 6]), channel_enable) & s_axis_tkeep[i];
            if (en[i]) last_lane = i;
            if (s_axis_tkeep[i] && !en[i]) dropped++;
        end
        for (int i = 0; i < 4; i++) begin
            if (en[i]) exp_q.push_back('{s_axis_tagtime[64*i +: 64],
                                         $signed(s_axis_channel[6*i +: 6]), i == last_lane});
        end
        sum      = {1'b0, exp_filt} + {1'b0, dropped};
        exp_filt = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        s_axis_tvalid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tagtime = '0;
        s_axis_channel = '0;
        s_axis_tkeep = '0;
        s_lowest_time_bound = '0;
        channel_enable = '1;
        m_axis_tready = 1'b1;

        @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tlast", 64'(m_axis_tlast), 64'd0);
        check("rst_sready", 64'(s_axis_tready), 64'd1);
        check("rst_time", m_axis_tagtime, 64'd0);
        check("rst_chan", 64'(m_axis_channel), 64'd0);
        check("rst_bound", lowest_time_bound, 64'd0);
        check("rst_filt", 64'(filtered_count), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Bound: empty bundles carry the upstream bound only.
        drive(0, 0, 0, 0, 1, 1, 1, 1, 4'b0000, 64'd1000);
        accept(w);
        idle_in();
        wait_cycles(2);
        check("bound_1000", lowest_time_bound, 64'd1000);
        check("bound_empty_novalid", 64'(m_axis_tvalid), 64'd0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 1, 1, 1, 1, 4'b0000, 64'd500);
        accept(w);
        idle_in();
        wait_cycles(3);
        check("bound_no_decrease", lowest_time_bound, 64'd1000);

        // All lanes, two bundles back to back.
        @(posedge clk); #1;
        drive(10, 20, 30, 40, 1, 2, 3, 4, 4'b1111, 64'd0);
        accept(w);
        drive(50, 60, 70, 80, -1, -2, -3, -4, 4'b1111, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("all_tvalid_a", 64'(m_axis_tvalid), 64'd1);
            check("all_sready_low", 64'(s_axis_tready), 64'd0);
        end
        accept(w);
        check("all_sready_4th", 64'(w), 64'd1);
        idle_in();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("all_tvalid_b", 64'(m_axis_tvalid), 64'd1);
        end
        wait_cycles(2);
        check("all_done", 64'(exp_q.size()), 64'd0);
        check("all_bound", lowest_time_bound, 64'd1000);

        // Sparse lanes; enable mask changes after capture must not matter.
        @(posedge clk); #1;
        drive(7, 100, 9, 200, 1, 3, 2, -2, 4'b1010, 64'd0);
        accept(w);
        idle_in();
        channel_enable = '0;
        wait_cycles(4);
        channel_enable = '1;
        check("sparse_done", 64'(exp_q.size()), 64'd0);
        check("sparse_filt", 64'(filtered_count), 64'(exp_filt));

        // Filtered lane.
        @(posedge clk); #1;
        channel_enable[2] = 1'b0;
        drive(300, 0, 0, 0, 3, 1, 1, 1, 4'b0001, 64'd0);
        accept(w);
        idle_in();
        wait_cycles(3);
        check("filter_novalid", 64'(m_axis_tvalid), 64'd0);
        check("filter_count", 64'(filtered_count), 64'd1);

        // Saturation from a preset near the top.
        force dut.filt_q = 32'hFFFF_FFFE;
        #1 release dut.filt_q;
        exp_filt = 32'hFFFF_FFFE;
        @(posedge clk); #1;
        drive(1, 2, 3, 4, 3, 0, -25, 5, 4'b0111, 64'd0);
        accept(w);
        idle_in();
        wait_cycles(3);
        check("filter_sat", 64'(filtered_count), 64'hFFFF_FFFF);
        check("filter_sat_model", 64'(filtered_count), 64'(exp_filt));
        channel_enable = '1;

        // Backpressure mid-bundle.
        @(posedge clk); #1;
        drive(4000, 4100, 4200, 5000, 5, 6, -7, -8, 4'b1111, 64'd0);
        accept(w);
        idle_in();
        @(negedge clk);
        @(posedge clk); #1;
        m_axis_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_tvalid", 64'(m_axis_tvalid), 64'd1);
            check("bp_time", m_axis_tagtime, exp_q[0].t);
            check("bp_chan", 64'(m_axis_channel), 64'(exp_q[0].c));
            check("bp_last", 64'(m_axis_tlast), 64'(exp_q[0].last));
            check("bp_sready", 64'(s_axis_tready), 64'd0);
        end
        @(posedge clk); #1;
        m_axis_tready = 1'b1;
        wait_cycles(6);
        check("bp_done", 64'(exp_q.size()), 64'd0);
        check("bp_bound", lowest_time_bound, 64'd5000);

        // Reset after the second tag of a four-tag bundle.
        @(posedge clk); #1;
        begin
            int base;
            base = pop_count;
            drive(6000, 6100, 6200, 6300, 1, 2, 3, 4, 4'b1111, 64'd0);
            accept(w);
            idle_in();
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                #1;
                if (pop_count >= base + 2) break;
            end
            check("rst_mid_pops", 64'(pop_count - base), 64'd2);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        exp_filt = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_mid_tlast", 64'(m_axis_tlast), 64'd0);
        check("rst_mid_sready", 64'(s_axis_tready), 64'd1);
        check("rst_mid_time", m_axis_tagtime, 64'd0);
        check("rst_mid_chan", 64'(m_axis_channel), 64'd0);
        check("rst_mid_bound", lowest_time_bound, 64'd0);
        check("rst_mid_filt", 64'(filtered_count), 64'd0);
        wait_cycles(4);
        check("rst_mid_quiet", 64'(m_axis_tvalid), 64'd0);
        check("final_queue", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
